// File: rtl/ham_pkg.sv
// Shared Hamming(7,4) types, sizes and the syndrome function.
package ham_pkg;
  localparam int HAM_N = 7;
  localparam int HAM_K = 4;

  typedef logic [HAM_N-1:0] ham_code_t;
  typedef logic [HAM_K-1:0] ham_data_t;
  typedef logic [2:0]       ham_syn_t;

  // The syndrome value equals the 1-based position of a single flipped bit.
  function automatic ham_syn_t ham_syndrome(input ham_code_t c);
    return {c[3] ^ c[4] ^ c[5] ^ c[6],
            c[1] ^ c[2] ^ c[5] ^ c[6],
            c[0] ^ c[2] ^ c[4] ^ c[6]};
  endfunction
endpackage

// File: rtl/ham_syndrome_correct.sv
// Combinational Hamming(7,4) syndrome and single-error correction of the data bits.
module ham_syndrome_correct
  import ham_pkg::*;
(
  input  ham_code_t code,
  output ham_syn_t  syndrome,
  output ham_data_t data
);
  assign syndrome = ham_syndrome(code);

  // Only the data positions (3,5,6,7) need the flip; parity fixes are never observed.
  assign data = {code[6] ^ (syndrome == 3'd7),
                 code[5] ^ (syndrome == 3'd6),
                 code[4] ^ (syndrome == 3'd5),
                 code[2] ^ (syndrome == 3'd3)};
endmodule

// File: rtl/ham_decoder_stream.sv
// Two-stage streaming Hamming(7,4) decoder with valid/ready on both sides.
// Define HAM_DEC_ERR_CNT_EN to build the saturating corrected-word counter.
module ham_decoder_stream
  import ham_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       in_code,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_data,
  output logic [2:0]       out_syndrome,
  output logic             out_corrected,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] err_cnt
);
  logic      s1_valid;
  ham_code_t s1_code;
  ham_syn_t  s1_syn;
  logic      advance;
  ham_syn_t  fix_syn;
  ham_data_t fix_data;

  assign advance  = ~out_valid | out_ready;
  // An empty stage 1 can still fill while the output is stalled.
  assign in_ready = ~s1_valid | advance;

  ham_syndrome_correct u_fix (
    .code     (s1_code),
    .syndrome (fix_syn),
    .data     (fix_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid      <= 1'b0;
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_syndrome  <= '0;
      out_corrected <= 1'b0;
    end else begin
      if (in_ready) s1_valid <= in_valid;
      if (advance) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_data      <= fix_data;
          out_syndrome  <= fix_syn;
          out_corrected <= |s1_syn;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (in_ready && in_valid) begin
      s1_code <= in_code;
      s1_syn  <= ham_syndrome(in_code);
    end
  end

`ifdef HAM_DEC_ERR_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n || cnt_clr)
      err_cnt <= '0;
    else if (out_valid && out_ready && out_corrected && (err_cnt != {CNT_W{1'b1}}))
      err_cnt <= err_cnt + 1'b1;
  end
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign err_cnt        = '0;
`endif
endmodule

// File: tb/tb_ham_decoder_stream.sv
// Randomized and directed bench for ham_decoder_stream against a position-XOR Hamming model.
module tb_ham_decoder_stream;
`ifdef HAM_DEC_ERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, in_valid, out_ready, cnt_clr;
  logic [6:0]  in_code;
  logic        in_ready, out_valid, out_corrected;
  logic [3:0]  out_data;
  logic [2:0]  out_syndrome;
  logic [15:0] err_cnt;
  logic        in_ready2, out_valid2, out_corrected2;
  logic [3:0]  out_data2;
  logic [2:0]  out_syndrome2;
  logic [1:0]  err_cnt2;

  always #5 clk = ~clk;

  ham_decoder_stream #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_syndrome(out_syndrome), .out_corrected(out_corrected), .cnt_clr(cnt_clr), .err_cnt(err_cnt));

  ham_decoder_stream #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2), .in_code(in_code),
    .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
    .out_syndrome(out_syndrome2), .out_corrected(out_corrected2), .cnt_clr(cnt_clr), .err_cnt(err_cnt2));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  typedef struct packed { logic [3:0] data; logic [2:0] syn; logic corr; } res_t;

  // Reference: syndrome is the XOR of the 1-based positions of all set bits.
  function automatic res_t ref_decode(input logic [6:0] c);
    res_t r;
    int pos;
    logic [6:0] w;
    pos = 0;
    for (int i = 0; i < 7; i++) if (c[i]) pos ^= (i + 1);
    w = c;
    if (pos != 0) w[pos-1] = ~w[pos-1];
    r.data = {w[6], w[5], w[4], w[2]};
    r.syn  = pos[2:0];
    r.corr = (pos != 0);
    return r;
  endfunction

  // Encoder: parity bits at positions 1,2,4 make the position-XOR of set bits zero.
  function automatic logic [6:0] encode(input logic [3:0] d);
    logic [6:0] c;
    int p;
    c = '0;
    c[2] = d[0]; c[4] = d[1]; c[5] = d[2]; c[6] = d[3];
    p = 0;
    for (int i = 0; i < 7; i++) if (c[i]) p ^= (i + 1);
    c[0] = p[0]; c[1] = p[1]; c[3] = p[2];
    return c;
  endfunction

  function automatic logic [6:0] flip(input int p);
    logic [6:0] m;
    m = '0;
    if (p != 0) m[p-1] = 1'b1;
    return m;
  endfunction

  res_t q[$];
  int   hs_cnt = 0;
  int   m_cnt16 = 0;
  int   m_cnt2 = 0;
  logic hold = 1'b0;
  logic [7:0] held;

  always @(negedge clk) begin
    res_t e;
    logic corr_hs;
    corr_hs = 1'b0;
    chk("cnt16", 32'(err_cnt), CNT_EN ? m_cnt16 : 0);
    chk("cnt2", 32'(err_cnt2), CNT_EN ? m_cnt2 : 0);
    if (hold) chk("hold", {out_valid, out_data, out_syndrome, out_corrected}, {1'b1, held});
    hold = rst_n && out_valid && !out_ready;
    held = {out_data, out_syndrome, out_corrected};
    if (!rst_n) begin
      q.delete();
      m_cnt16 = 0;
      m_cnt2  = 0;
    end else begin
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("spurious_out", 32'(out_valid), 0);
        else begin
          e = q.pop_front();
          chk("data", 32'(out_data), 32'(e.data));
          chk("syn", 32'(out_syndrome), 32'(e.syn));
          chk("corr", 32'(out_corrected), 32'(e.corr));
          corr_hs = e.corr;
          hs_cnt++;
        end
      end
      if (cnt_clr) begin
        m_cnt16 = 0;
        m_cnt2  = 0;
      end else if (corr_hs) begin
        if (m_cnt16 != 65535) m_cnt16++;
        if (m_cnt2 != 3) m_cnt2++;
      end
      if (in_valid && in_ready) q.push_back(ref_decode(in_code));
    end
  end

  initial begin
    int  hs0, acc_n;
    logic acc;
    rst_n = 1'b0; in_valid = 1'b0; in_code = '0; out_ready = 1'b1; cnt_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_fields", {out_data, out_syndrome, out_corrected}, 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_err_cnt", 32'(err_cnt), 0);
    rst_n = 1'b1;

    // clean word, two-cycle latency
    in_valid = 1'b1; in_code = 7'b1010101;
    @(negedge clk); chk("d1_accept", 32'(in_ready), 1);
    @(posedge clk); #1; in_valid = 1'b0;
    @(negedge clk); chk("d1_lat_early", 32'(out_valid), 0);
    @(negedge clk); chk("d1_valid", 32'(out_valid), 1);
    chk("d1_data", 32'(out_data), 32'(4'b1011));
    chk("d1_syn", 32'(out_syndrome), 0);
    chk("d1_corr", 32'(out_corrected), 0);
    @(posedge clk); #1;

    // position 5 flipped
    in_valid = 1'b1; in_code = 7'b1000101;
    @(posedge clk); #1; in_valid = 1'b0;
    @(negedge clk); chk("d2_lat_early", 32'(out_valid), 0);
    @(negedge clk); chk("d2_valid", 32'(out_valid), 1);
    chk("d2_data", 32'(out_data), 32'(4'b1011));
    chk("d2_syn", 32'(out_syndrome), 32'(3'b101));
    chk("d2_corr", 32'(out_corrected), 1);
    @(posedge clk); #1;
    chk("d2_cnt", 32'(err_cnt), CNT_EN ? 1 : 0);

    // 16 data values x 8 error patterns, back-to-back
    cnt_clr = 1'b1;
    @(posedge clk); #1; cnt_clr = 1'b0;
    hs0 = hs_cnt;
    for (int d = 0; d < 16; d++)
      for (int p = 0; p < 8; p++) begin
        in_valid = 1'b1; in_code = encode(4'(d)) ^ flip(p);
        @(negedge clk); chk("stream_rdy", 32'(in_ready), 1);
        @(posedge clk); #1;
      end
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("stream_count", 32'(hs_cnt - hs0), 128);
    chk("stream_err_cnt", 32'(err_cnt), CNT_EN ? 112 : 0);
    chk("sat_cnt2", 32'(err_cnt2), CNT_EN ? 3 : 0);

    // clear wins over a simultaneous corrected handshake
    in_valid = 1'b1; in_code = encode(4'd5) ^ flip(1);
    @(posedge clk); #1; in_valid = 1'b0;
    @(posedge clk); #1; cnt_clr = 1'b1;
    @(negedge clk); chk("clr_hs", 32'(out_valid && out_ready && out_corrected), 1);
    @(posedge clk); #1; cnt_clr = 1'b0;
    chk("clr_cnt16", 32'(err_cnt), 0);
    chk("clr_cnt2", 32'(err_cnt2), 0);

    // back-pressure with continuous offers
    out_ready = 1'b0; hs0 = hs_cnt; acc_n = 0; acc = 1'b1;
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (acc) in_code = encode(4'($urandom)) ^ flip(int'($urandom_range(0, 7)));
      @(negedge clk); acc = in_ready; if (acc) acc_n++;
      @(posedge clk); #1;
    end
    chk("stall_accepts", 32'(acc_n), 2);
    chk("stall_in_ready", 32'(in_ready), 0);
    out_ready = 1'b1;
    @(negedge clk); chk("stall_release_rdy", 32'(in_ready), 1);
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("stall_drain", 32'(hs_cnt - hs0), 3);
    chk("stall_queue", 32'(q.size()), 0);

    // reset with two corrected words in flight
    out_ready = 1'b0; hs0 = hs_cnt;
    in_valid = 1'b1; in_code = encode(4'd9) ^ flip(2);
    @(posedge clk); #1; in_code = encode(4'd6) ^ flip(7);
    @(posedge clk); #1; in_valid = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    chk("rr_out_valid", 32'(out_valid), 0);
    chk("rr_in_ready", 32'(in_ready), 1);
    chk("rr_err_cnt", 32'(err_cnt), 0);
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("rr_no_output", 32'(hs_cnt - hs0), 0);

    // random traffic, including double errors (miscorrection is expected)
    acc = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      if (!in_valid || acc) begin
        in_valid = ($urandom % 4) != 0;
        if ($urandom % 8 == 0) in_code = 7'($urandom);
        else in_code = encode(4'($urandom)) ^ flip(int'($urandom_range(0, 7)));
      end
      out_ready = ($urandom % 3) != 0;
      cnt_clr   = ($urandom % 64) == 0;
      @(negedge clk); acc = in_valid && in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("rand_drain", 32'(q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ham_decoder_stream.md
HAM_DECODER_STREAM -- requirements
Module: ham_decoder_stream

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of the corrected-error counter.
REQ-002 SHALL have port clk, input, 1: single clock; all logic on the rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-004 SHALL have port in_valid, input, 1: a codeword is offered.
REQ-005 SHALL have port in_ready, output, 1: the block accepts a codeword this cycle.
REQ-006 SHALL have port in_code, input, 7: Hamming(7,4) codeword; bit i is position i+1; data bits at [2],[4],[5],[6]; parity bits at [0],[1],[3].
REQ-007 SHALL have port out_valid, output, 1: the decoded result is valid.
REQ-008 SHALL have port out_ready, input, 1: the consumer takes the result.
REQ-009 SHALL have port out_data, output, 4: corrected data, {code[6],code[5],code[4],code[2]}.
REQ-010 SHALL have port out_syndrome, output, 3: syndrome of the received word.
REQ-011 SHALL have port out_corrected, output, 1: the syndrome was nonzero and one bit was flipped.
REQ-012 SHALL have port cnt_clr, input, 1: synchronous clear of the error counter.
REQ-013 SHALL have port err_cnt, output, CNT_W: saturating count of corrected words.

Function
REQ-014 SHALL compute syndrome s0=c0^c2^c4^c6, s1=c1^c2^c5^c6, s2=c3^c4^c5^c6; syndrome={s2,s1,s0}.
REQ-015 SHALL, for syndrome S!=0, invert code bit S-1 before data extraction; for S=0, pass the word unchanged.
REQ-016 SHALL be a 2-stage pipeline: stage 1 registers the codeword and syndrome; stage 2 registers out_data, out_syndrome, out_corrected and out_valid.
REQ-017 SHALL give a latency of exactly 2 cycles from the accepting edge (in_valid&in_ready) to out_valid high, when there is no back-pressure.
REQ-018 SHALL define advance = ~out_valid | out_ready; both stages move only when advance=1.
REQ-019 SHALL drive in_ready = ~s1_valid | advance, combinationally, with no dependency on in_valid.
REQ-020 SHALL hold all output fields stable while out_valid=1 and out_ready=0.
REQ-021 SHALL, when the pipeline is full and back-pressured, accept nothing and drop nothing.
REQ-022 SHALL sustain 1 word/cycle throughput when out_ready is held at 1.
REQ-023 SHALL increment err_cnt by 1 on each output handshake (out_valid&out_ready) with out_corrected=1, and SHALL hold it at all-ones once saturated.
REQ-024 SHALL give cnt_clr priority over a simultaneous increment: the counter becomes 0 that cycle.
REQ-025 SHALL not detect double-bit errors; a double error yields a miscorrection, and this is the documented behaviour.

Reset
REQ-026 SHALL, while rst_n=0 at a clock edge, clear s1_valid, out_valid, out_data, out_syndrome, out_corrected and err_cnt to 0.
REQ-027 SHALL, on reset during an active transfer, discard any in-flight words; in_ready=1 on the first cycle after release.

Configuration
REQ-028 SHALL, with HAM_DEC_ERR_CNT_EN defined, implement the err_cnt and cnt_clr logic per REQ-023 and REQ-024.
REQ-029 SHALL, with HAM_DEC_ERR_CNT_EN undefined, tie err_cnt to 0, ignore cnt_clr, and create no counter flops; the ports stay present.

Structure
REQ-030 SHALL take the following from the shared package ham_pkg: constants HAM_N=7 and HAM_K=4, typedefs ham_code_t[6:0], ham_data_t[3:0] and ham_syn_t[2:0], and a pure function for the syndrome.
REQ-031 SHALL place syndrome computation and correction in one combinational sub-module, ham_syndrome_correct (code in -> syndrome and corrected data out), instantiated at stage 1 or stage 2.

Verification
REQ-032 SHALL cover: in_code=1010101 (data 1011) with out_ready=1 -> 2 cycles later out_data=1011, out_syndrome=000, out_corrected=0.
REQ-033 SHALL cover: in_code=1000101 (position 5 flipped) -> out_data=1011, out_syndrome=101, out_corrected=1, err_cnt=1.
REQ-034 SHALL cover all 16 data values x 8 error patterns (none or single, positions 1-7) streamed back-to-back -> every out_data correct, 1 result/cycle, err_cnt=112.
REQ-035 SHALL cover: out_ready=0 for 5 cycles with in_valid=1 -> in_ready falls after 2 accepts, outputs held stable, no loss or duplication after release.
REQ-036 SHALL cover: CNT_W=2, 5 corrected words -> err_cnt saturates at 3; cnt_clr with a simultaneous corrected handshake -> err_cnt=0.
REQ-037 SHALL cover: rst_n low for 1 cycle with 2 words in flight -> out_valid=0 next cycle, those words are never output, err_cnt=0.
